// File: rtl/nsc_pkg.sv
// nsc_pkg: shared types, constants and helpers for the nibble-serial
// magnitude comparator.
//   NIBBLE_W     : width of one compared slice
//   casc_t       : {gt, lt, eq} cascade word, 74HC85 semantics
//   CASC_*       : the five cascade codes that can occur
//   casc_decode  : maps raw cascade-in pins to a casc_t (74HC85 table)
package nsc_pkg;

  localparam int NIBBLE_W = 4;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } casc_t;

  localparam casc_t CASC_GT   = 3'b100;
  localparam casc_t CASC_LT   = 3'b010;
  localparam casc_t CASC_EQ   = 3'b001;
  localparam casc_t CASC_NONE = 3'b000;
  localparam casc_t CASC_BOTH = 3'b110;

  // ieq dominates; otherwise igt/ile pass through, with the two
  // degenerate combinations producing NONE (both high) or BOTH (both low).
  function automatic casc_t casc_decode(input logic igt, input logic ile,
                                        input logic ieq);
    casc_t res;
    if (ieq) begin
      res = CASC_EQ;
    end else begin
      case ({igt, ile})
        2'b10:   res = CASC_GT;
        2'b01:   res = CASC_LT;
        2'b11:   res = CASC_NONE;
        default: res = CASC_BOTH;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/nsc_nibble_stage.sv
// nsc_nibble_stage: one combinational 74HC85-style compare stage.
// Ports:
//   a, b      in  NIBBLE_W  nibbles to compare
//   casc_in   in  casc_t    result of the lower-order comparison
//   casc_out  out casc_t    GT/LT if the nibbles differ, else casc_in
module nsc_nibble_stage
  import nsc_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  casc_t               casc_in,
  output casc_t               casc_out
);

  always_comb begin
    casc_out = casc_in;
    if (a > b) begin
      casc_out = CASC_GT;
    end else if (a < b) begin
      casc_out = CASC_LT;
    end
  end

endmodule

// File: rtl/nibble_serial_comp.sv
// nibble_serial_comp: multi-cycle magnitude comparator, one nibble per clock.
// Operands and cascade-in are latched on an accepted start; the running
// cascade word is folded through nsc_nibble_stage once per RUN cycle.
// Build option: NSC_EARLY_EXIT_EN selects an MSB-first scan that finishes
// at the first unequal nibble (latency 1..NIBBLES); undefined gives a fixed
// NIBBLES-cycle LSB-first scan. Final results are identical in both builds.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               compare request, sampled only when busy=0
//   a, b                operands (4*NIBBLES bits), sampled with start
//   igt, ile, ieq       cascade-in from a lower-order comparator
//   busy                compare in progress
//   done                one-cycle pulse, fgt/fle/feq updated
//   fgt, fle, feq       result A>B, A<B, A=B (held until next done)
module nibble_serial_comp
  import nsc_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        igt,
  input  logic                        ile,
  input  logic                        ieq,
  output logic                        busy,
  output logic                        done,
  output logic                        fgt,
  output logic                        fle,
  output logic                        feq
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  // state | meaning
  // IDLE  | waiting for start, results held
  // RUN   | folding one nibble per clock into the running cascade word
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  casc_t            run_q, run_d;
  casc_t            res_q, res_d;
  logic             done_q, done_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b;
  casc_t               stage_out;
  logic                last;
  logic [CNT_W-1:0]    cnt_first, cnt_next;

  assign nib_a = a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*cnt_q +: NIBBLE_W];

  nsc_nibble_stage u_stage (
    .a        (nib_a),
    .b        (nib_b),
    .casc_in  (run_q),
    .casc_out (stage_out)
  );

`ifdef NSC_EARLY_EXIT_EN
  // MSB-first: the first unequal nibble decides, lower nibbles cannot change it.
  assign cnt_first = CNT_LAST;
  assign cnt_next  = cnt_q - 1'b1;
  assign last      = (cnt_q == '0) || (nib_a != nib_b);
`else
  // LSB-first: a higher differing nibble overrides any lower-order result.
  assign cnt_first = '0;
  assign cnt_next  = cnt_q + 1'b1;
  assign last      = (cnt_q == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      run_q   <= CASC_NONE;
      res_q   <= CASC_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          run_d   = casc_decode(igt, ile, ieq);
          cnt_d   = cnt_first;
          state_d = RUN;
        end
      end
      RUN: begin
        run_d = stage_out;
        cnt_d = cnt_next;
        if (last) begin
          res_d   = stage_out;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign fgt  = res_q.gt;
  assign fle  = res_q.lt;
  assign feq  = res_q.eq;

endmodule

// File: tb/tb_nibble_serial_comp.sv
// Scoreboard bench for nibble_serial_comp (NIBBLES=4). Stimulus pushes the
// expected result and latency; a negedge monitor pops on every done.
module tb_nibble_serial_comp;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         igt, ile, ieq;
  logic         busy, done, fgt, fle, feq;

  typedef struct {
    logic [2:0] res;
    int         start_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  nibble_serial_comp #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .igt   (igt),
    .ile   (ile),
    .ieq   (ieq),
    .busy  (busy),
    .done  (done),
    .fgt   (fgt),
    .fle   (fle),
    .feq   (feq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-operand integer compare; ties fall back to cascade-in.
  function automatic logic [2:0] ref_res(input logic [W-1:0] ra, rb,
                                         input logic rgt, rlt, req);
    if (ra > rb) return 3'b100;
    if (ra < rb) return 3'b010;
    if (req) return 3'b001;
    if (rgt && !rlt) return 3'b100;
    if (!rgt && rlt) return 3'b010;
    if (rgt && rlt) return 3'b000;
    return 3'b110;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] ra, rb);
`ifdef NSC_EARLY_EXIT_EN
    for (int i = NIB - 1; i >= 0; i--)
      if (ra[4*i +: 4] != rb[4*i +: 4]) return NIB - i;
`endif
    return NIB;
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'({fgt, fle, feq}), 32'(e.res));
        check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, ib, input logic iigt, iile, iieq);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      check("issue_timeout", 32'(busy), 32'd0);
      return;
    end
    a = ia; b = ib; igt = iigt; ile = iile; ieq = iieq;
    start = 1'b1;
    sb.push_back('{res: ref_res(ia, ib, iigt, iile, iieq), start_cyc: cyc + 1,
                   lat: ref_lat(ia, ib)});
    @(negedge clk);
    start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    igt = 1'($urandom_range(0, 1));
    ile = 1'($urandom_range(0, 1));
    ieq = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    igt = 1'b0; ile = 1'b0; ieq = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fgt", 32'(fgt), 32'd0);
    check("rst_fle", 32'(fle), 32'd0);
    check("rst_feq", 32'(feq), 32'd0);

    issue(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1);
    issue(16'hB000, 16'h4FFF, 1'b0, 1'b0, 1'b1);
    issue(16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    issue(16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    issue(16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    issue(16'hBEEF, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    issue(16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    drain();
    check("hold_fgt", 32'(fgt), 32'd1);
    check("hold_fle", 32'(fle), 32'd1);
    check("hold_feq", 32'(feq), 32'd0);

    // Start pulse mid-run must be ignored; next start issued in the done cycle.
    issue(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b1);
    a = 16'hFFFF; b = 16'h0000; ieq = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    drain();

    // Abort mid-run: leave a nonzero result first so the reset is visible.
    issue(16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0);
    drain();
    issue(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'({fgt, fle, feq}), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_abort_out", 32'({fgt, fle, feq}), 32'd0);
    check("post_abort_busy", 32'(busy), 32'd0);
    issue(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       begin rb = ra; rb[4*$urandom_range(0, NIB-1) +: 4] = 4'($urandom); end
        default: rb = W'($urandom);
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
